// File: rtl/clock_set_display.sv
// Time-set FSM and digit-word producer for the 8-digit display; d1..d8, load_* and edit_mode_o are registered.
// Display follows the time inputs with 1 cycle of latency; there is no backpressure and the outputs update every clock.
module clock_set_display #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic [4:0] hours_i,
  input  logic [5:0] minutes_i,
  input  logic [5:0] seconds_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       config_i,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [7:0] d4,
  output logic [7:0] d5,
  output logic [7:0] d6,
  output logic [7:0] d7,
  output logic [7:0] d8,
  output logic       load_o,
  output logic [4:0] load_hours_o,
  output logic [5:0] load_minutes_o,
  output logic [1:0] edit_mode_o
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_inc, r_inc_q, r_dec, r_dec_q, r_cfg, r_cfg_q;
  logic [4:0]    r_edit_h;
  logic [5:0]    r_edit_m;
  logic [CW-1:0] r_cnt;
  logic          r_hidden;
  logic          r_load;
  logic [4:0]    r_load_h;
  logic [5:0]    r_load_m;
  logic [7:0]    r_dig [8];

  state_t        w_state_nxt;
  logic [4:0]    w_edit_h_nxt;
  logic [5:0]    w_edit_m_nxt;
  logic          w_load_nxt;
  logic          w_restart;
  logic          w_inc_edge, w_dec_edge, w_cfg_edge, w_step;
  logic [5:0]    w_hv, w_mv, w_sv;
  logic          w_h_en, w_m_en;

  function automatic logic [7:0] f_dig(input logic en, input logic [3:0] val, input logic dp);
    return {2'b00, en, val, dp};
  endfunction

  function automatic logic [3:0] f_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] f_units(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  assign w_inc_edge = r_inc & ~r_inc_q;
  assign w_dec_edge = r_dec & ~r_dec_q;
  assign w_cfg_edge = r_cfg & ~r_cfg_q;
  // Simultaneous inc and dec cancel out
  assign w_step     = w_inc_edge ^ w_dec_edge;

  always_comb begin
    w_state_nxt  = r_state;
    w_edit_h_nxt = r_edit_h;
    w_edit_m_nxt = r_edit_m;
    w_load_nxt   = 1'b0;
    w_restart    = 1'b0;
    if (w_cfg_edge) begin
      w_restart = 1'b1;
      case (r_state)
        RUN: begin
          w_state_nxt  = SET_H;
          w_edit_h_nxt = hours_i;
          w_edit_m_nxt = minutes_i;
        end
        SET_H:   w_state_nxt = SET_M;
        SET_M: begin
          w_state_nxt = RUN;
          w_load_nxt  = 1'b1;
        end
        default: w_state_nxt = RUN;
      endcase
    end else if (w_step && (r_state != RUN)) begin
      w_restart = 1'b1;
      if (r_state == SET_H) begin
        if (w_inc_edge) w_edit_h_nxt = (r_edit_h == 5'd23) ? 5'd0 : r_edit_h + 5'd1;
        else            w_edit_h_nxt = (r_edit_h == 5'd0) ? 5'd23 : r_edit_h - 5'd1;
      end else begin
        if (w_inc_edge) w_edit_m_nxt = (r_edit_m == 6'd59) ? 6'd0 : r_edit_m + 6'd1;
        else            w_edit_m_nxt = (r_edit_m == 6'd0) ? 6'd59 : r_edit_m - 6'd1;
      end
    end
  end

  always_comb begin
    w_hv   = {1'b0, hours_i};
    w_mv   = minutes_i;
    w_sv   = seconds_i;
    w_h_en = 1'b1;
    w_m_en = 1'b1;
    if (r_state != RUN) begin
      w_hv   = {1'b0, r_edit_h};
      w_mv   = r_edit_m;
      w_sv   = 6'd0;
      w_h_en = !((r_state == SET_H) && r_hidden);
      w_m_en = !((r_state == SET_M) && r_hidden);
    end
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= RUN;
      r_inc    <= 1'b0;
      r_inc_q  <= 1'b0;
      r_dec    <= 1'b0;
      r_dec_q  <= 1'b0;
      r_cfg    <= 1'b0;
      r_cfg_q  <= 1'b0;
      r_edit_h <= '0;
      r_edit_m <= '0;
      r_cnt    <= '0;
      r_hidden <= 1'b0;
      r_load   <= 1'b0;
      r_load_h <= '0;
      r_load_m <= '0;
      for (int i = 0; i < 8; i++) r_dig[i] <= '0;
    end else begin
      r_inc    <= inc_i;
      r_inc_q  <= r_inc;
      r_dec    <= dec_i;
      r_dec_q  <= r_dec;
      r_cfg    <= config_i;
      r_cfg_q  <= r_cfg;
      r_state  <= w_state_nxt;
      r_edit_h <= w_edit_h_nxt;
      r_edit_m <= w_edit_m_nxt;
      r_load   <= w_load_nxt;
      r_load_h <= w_load_nxt ? r_edit_h : 5'd0;
      r_load_m <= w_load_nxt ? r_edit_m : 6'd0;
      // Blink restarts visible on every edit so the new value shows at once
      if ((w_state_nxt == RUN) || w_restart) begin
        r_cnt    <= '0;
        r_hidden <= 1'b0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt    <= '0;
        r_hidden <= ~r_hidden;
      end else begin
        r_cnt    <= r_cnt + CW'(1);
      end
      r_dig[7] <= f_dig(w_h_en, f_tens(w_hv), 1'b0);
      r_dig[6] <= f_dig(w_h_en, f_units(w_hv), 1'b1);
      r_dig[5] <= 8'h00;
      r_dig[4] <= f_dig(w_m_en, f_tens(w_mv), 1'b0);
      r_dig[3] <= f_dig(w_m_en, f_units(w_mv), 1'b1);
      r_dig[2] <= 8'h00;
      r_dig[1] <= f_dig(1'b1, f_tens(w_sv), 1'b0);
      r_dig[0] <= f_dig(1'b1, f_units(w_sv), 1'b0);
    end
  end

  assign d1             = r_dig[0];
  assign d2             = r_dig[1];
  assign d3             = r_dig[2];
  assign d4             = r_dig[3];
  assign d5             = r_dig[4];
  assign d6             = r_dig[5];
  assign d7             = r_dig[6];
  assign d8             = r_dig[7];
  assign load_o         = r_load;
  assign load_hours_o   = r_load_h;
  assign load_minutes_o = r_load_m;
  assign edit_mode_o    = r_state;

endmodule

// File: tb/tb_clock_set_display.sv
// Directed bench for clock_set_display with BLINK_DIV = 8.
module tb_clock_set_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       inc = 1'b0, dec = 1'b0, cfg = 1'b0;
  logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       load;
  logic [4:0] load_h;
  logic [5:0] load_m;
  logic [1:0] mode;
  logic [63:0] all_d;

  int n_vec = 0;
  int n_err = 0;

  assign all_d = {d8, d7, d6, d5, d4, d3, d2, d1};

  always #5 clk = ~clk;

  clock_set_display #(.BLINK_DIV(8)) dut (
    .clk_100MHz_i(clk), .reset_i(rst_n),
    .hours_i(hours), .minutes_i(minutes), .seconds_i(seconds),
    .inc_i(inc), .dec_i(dec), .config_i(cfg),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .load_o(load), .load_hours_o(load_h), .load_minutes_o(load_m),
    .edit_mode_o(mode)
  );

  function automatic logic [7:0] enc(input bit en, input int v, input bit dp);
    logic [3:0] vv;
    vv = v[3:0];
    return {2'b00, en, vv, dp};
  endfunction

  // One-cycle button pulse; returns once the resulting display update is visible
  task automatic pulse(input bit p_inc, input bit p_dec, input bit p_cfg);
    @(negedge clk);
    inc = p_inc; dec = p_dec; cfg = p_cfg;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; cfg = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [63:0] exp_d;
    rst_n = 1'b0; hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (all_d[i*8 +: 8] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_d%0d: got %h want 00", i + 1, all_d[i*8 +: 8]);
      end
    end
    n_vec++;
    if ({load, load_h, load_m, mode} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_ctl: load=%b lh=%0d lm=%0d mode=%0d want all 0", load, load_h, load_m, mode);
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp_d = {enc(1, 1, 0), enc(1, 2, 1), 8'h00, enc(1, 3, 0), enc(1, 4, 1), 8'h00, enc(1, 5, 0), enc(1, 6, 0)};
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (all_d[i*8 +: 8] !== exp_d[i*8 +: 8]) begin
        n_err++;
        $display("FAIL run_d%0d: got %h want %h", i + 1, all_d[i*8 +: 8], exp_d[i*8 +: 8]);
      end
    end
  endtask

  task automatic test_set_hours;
    hours = 5'd23; minutes = 6'd59; seconds = 6'd10;
    pulse(0, 0, 1);
    n_vec++;
    if (mode !== 2'd1) begin n_err++; $display("FAIL seth_mode: got %0d want 1", mode); end
    n_vec++;
    if ({d8, d7, d5, d4, d2, d1} !== {enc(1, 2, 0), enc(1, 3, 1), enc(1, 5, 0), enc(1, 9, 1), enc(1, 0, 0), enc(1, 0, 0)}) begin
      n_err++;
      $display("FAIL seth_digits: got %h %h %h %h %h %h want 24 27 2a 33 20 20", d8, d7, d5, d4, d2, d1);
    end
    repeat (7) @(negedge clk);
    n_vec++;
    if (d8[5] !== 1'b1) begin n_err++; $display("FAIL blink_vis: d8 en got %b want 1", d8[5]); end
    @(negedge clk);
    n_vec++;
    if ({d8[5], d7[5], d5[5]} !== 3'b001) begin
      n_err++;
      $display("FAIL blink_hid: en d8/d7/d5 got %b want 001", {d8[5], d7[5], d5[5]});
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if ({d8[5], d7[5]} !== 2'b11) begin n_err++; $display("FAIL blink_back: en got %b want 11", {d8[5], d7[5]}); end
    pulse(1, 0, 0);
    n_vec++;
    if ({d8, d7} !== {enc(1, 0, 0), enc(1, 0, 1)}) begin
      n_err++; $display("FAIL inc_wrap_h: got %h %h want 20 21", d8, d7);
    end
    pulse(0, 1, 0);
    n_vec++;
    if ({d8, d7} !== {enc(1, 2, 0), enc(1, 3, 1)}) begin
      n_err++; $display("FAIL dec_wrap_h: got %h %h want 24 27", d8, d7);
    end
  endtask

  task automatic test_set_minutes;
    pulse(0, 0, 1);
    n_vec++;
    if (mode !== 2'd2) begin n_err++; $display("FAIL setm_mode: got %0d want 2", mode); end
    pulse(1, 0, 0);
    n_vec++;
    if ({d8, d7, d5, d4} !== {enc(1, 2, 0), enc(1, 3, 1), enc(1, 0, 0), enc(1, 0, 1)}) begin
      n_err++; $display("FAIL inc_wrap_m: got %h %h %h %h want 24 27 20 21", d8, d7, d5, d4);
    end
    pulse(0, 1, 0);
    n_vec++;
    if ({d5, d4} !== {enc(1, 5, 0), enc(1, 9, 1)}) begin
      n_err++; $display("FAIL dec_wrap_m: got %h %h want 2a 33", d5, d4);
    end
  endtask

  task automatic test_load;
    int n_load;
    n_load = 0;
    @(negedge clk);
    cfg = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg = 1'b0;
      n_vec++;
      if (load === 1'b1) begin
        n_load++;
        if ({load_h, load_m} !== {5'd23, 6'd59}) begin
          n_err++; $display("FAIL load_val: got %0d:%0d want 23:59", load_h, load_m);
        end
      end else if ({load_h, load_m} !== 11'd0) begin
        n_err++; $display("FAIL load_idle: got %0d:%0d want 0:0", load_h, load_m);
      end
    end
    n_vec++;
    if (n_load !== 1) begin n_err++; $display("FAIL load_count: got %0d want 1", n_load); end
    n_vec++;
    if (mode !== 2'd0) begin n_err++; $display("FAIL load_mode: got %0d want 0", mode); end
  endtask

  task automatic test_simultaneous;
    hours = 5'd5; minutes = 6'd7;
    pulse(0, 0, 1);
    pulse(1, 1, 0);
    n_vec++;
    if ({mode, d8, d7} !== {2'd1, enc(1, 0, 0), enc(1, 5, 1)}) begin
      n_err++; $display("FAIL inc_dec_both: mode %0d d8 %h d7 %h want 1 20 2b", mode, d8, d7);
    end
    pulse(1, 0, 1);
    n_vec++;
    if ({mode, d8, d7, d5, d4} !== {2'd2, enc(1, 0, 0), enc(1, 5, 1), enc(1, 0, 0), enc(1, 7, 1)}) begin
      n_err++;
      $display("FAIL cfg_inc_same: mode %0d d %h %h %h %h want 2 20 2b 20 2f", mode, d8, d7, d5, d4);
    end
  endtask

  task automatic test_run_ignore;
    int n_load;
    n_load = 0;
    pulse(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inc = (k != 1); dec = (k != 0);
      @(negedge clk);
      inc = 1'b0; dec = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (load !== 1'b0) n_load++;
      end
    end
    n_vec++;
    if (n_load !== 0) begin n_err++; $display("FAIL run_no_load: got %0d pulses want 0", n_load); end
    n_vec++;
    if (mode !== 2'd0) begin n_err++; $display("FAIL run_mode: got %0d want 0", mode); end
    hours = 5'd9;
    @(negedge clk);
    n_vec++;
    if ({d8, d7} !== {enc(1, 0, 0), enc(1, 9, 1)}) begin
      n_err++; $display("FAIL run_follow: got %h %h want 20 33", d8, d7);
    end
  endtask

  task automatic test_hold;
    pulse(0, 0, 1);
    @(negedge clk);
    inc = 1'b1;
    repeat (100) @(negedge clk);
    inc = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({d8[4:1], d7[4:1]} !== {4'd1, 4'd0}) begin
      n_err++; $display("FAIL hold_inc: got %0d%0d want 10", d8[4:1], d7[4:1]);
    end
  endtask

  task automatic test_reset_mid_edit;
    int n_load;
    n_load = 0;
    pulse(0, 0, 1);
    n_vec++;
    if (mode !== 2'd2) begin n_err++; $display("FAIL pre_rst_mode: got %0d want 2", mode); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mode, load, all_d} !== 67'd0) begin
      n_err++; $display("FAIL async_rst: mode %0d load %b d %h want all 0", mode, load, all_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (load !== 1'b0) n_load++;
    end
    n_vec++;
    if (n_load !== 0) begin n_err++; $display("FAIL rst_no_load: got %0d pulses want 0", n_load); end
    n_vec++;
    if ({mode, d8, d7} !== {2'd0, enc(1, 0, 0), enc(1, 9, 1)}) begin
      n_err++; $display("FAIL rst_run: mode %0d d %h %h want 0 20 33", mode, d8, d7);
    end
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_set_minutes();
    test_load();
    test_simultaneous();
    test_run_ignore();
    test_hold();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
